// File: rtl/sparc_fetch_pkg.sv
// Shared types and SPARC trap-type codes for the instruction fetch stage.
package sparc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    TRAP
  } fetch_state_t;

  localparam logic [7:0] TT_MISALIGN = 8'h07;
  localparam logic [7:0] TT_IACC_ERR = 8'h21;
  localparam logic [7:0] TT_IACC_EXC = 8'h01;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last cycle
// before the fetch must be abandoned.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one bus read per PC, holds the word for decode, pulses the PC
// increment on consume and raises instruction-access traps.
module instr_fetch_unit
  import sparc_fetch_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_en,
  input  logic        redirect,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_consume,
  output logic        pcs_inc,
  output logic        trap_req,
  output logic [7:0]  trap_tt,
  input  logic        trap_ack
);

  fetch_state_t state, state_next;
  logic [31:0]  mem_addr_next, ir_out_next;
  logic         mem_rd_next, ir_valid_next, pcs_inc_next, trap_req_next;
  logic [7:0]   trap_tt_next;
  logic         discard, discard_next;
  logic         expired;
  logic         drop;

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (state == REQ),
    .expired(expired)
  );

  // A redirect seen earlier in this bus cycle, or right now, kills its result.
  assign drop = discard | redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ir_out   <= '0;
      ir_valid <= 1'b0;
      pcs_inc  <= 1'b0;
      trap_req <= 1'b0;
      trap_tt  <= '0;
      discard  <= 1'b0;
    end else begin
      state    <= state_next;
      mem_addr <= mem_addr_next;
      mem_rd   <= mem_rd_next;
      ir_out   <= ir_out_next;
      ir_valid <= ir_valid_next;
      pcs_inc  <= pcs_inc_next;
      trap_req <= trap_req_next;
      trap_tt  <= trap_tt_next;
      discard  <= discard_next;
    end
  end

  always_comb begin
    state_next    = state;
    mem_addr_next = mem_addr;
    mem_rd_next   = mem_rd;
    ir_out_next   = ir_out;
    ir_valid_next = ir_valid;
    pcs_inc_next  = 1'b0;
    trap_req_next = trap_req;
    trap_tt_next  = trap_tt;
    discard_next  = discard;

    unique case (state)
      IDLE: begin
        if (fetch_en && !redirect) begin
          if (pc[1:0] != 2'b00) begin
            trap_req_next = 1'b1;
            trap_tt_next  = TT_MISALIGN;
            state_next    = TRAP;
          end else begin
            mem_addr_next = pc;
            mem_rd_next   = 1'b1;
            state_next    = REQ;
          end
        end
      end

      REQ: begin
        if (mem_ack) begin
          mem_rd_next  = 1'b0;
          discard_next = 1'b0;
          if (drop) begin
            state_next = IDLE;
          end else if (mem_err) begin
            trap_req_next = 1'b1;
            trap_tt_next  = TT_IACC_ERR;
            state_next    = TRAP;
          end else begin
            ir_out_next   = mem_rdata;
            ir_valid_next = 1'b1;
            state_next    = HOLD;
          end
        end else if (expired) begin
          mem_rd_next  = 1'b0;
          discard_next = 1'b0;
          if (drop) begin
            state_next = IDLE;
          end else begin
            trap_req_next = 1'b1;
            trap_tt_next  = TT_IACC_EXC;
            state_next    = TRAP;
          end
        end else if (redirect) begin
          discard_next = 1'b1;
        end
      end

      HOLD: begin
        // Redirect wins so pcs_inc never collides with a PC/nPC write.
        if (redirect) begin
          ir_valid_next = 1'b0;
          state_next    = IDLE;
        end else if (ir_consume) begin
          ir_valid_next = 1'b0;
          pcs_inc_next  = 1'b1;
          state_next    = IDLE;
        end
      end

      TRAP: begin
        if (trap_ack) begin
          trap_req_next = 1'b0;
          trap_tt_next  = '0;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of fetched words plus
// directed trap, redirect and reset scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_consume = 1'b0;
  logic        pcs_inc;
  logic        trap_req;
  logic [7:0]  trap_tt;
  logic        trap_ack = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_ir[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .TIMEOUT(4),
    .TMR_W  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .fetch_en  (fetch_en),
    .redirect  (redirect),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_err   (mem_err),
    .mem_rdata (mem_rdata),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .ir_consume(ir_consume),
    .pcs_inc   (pcs_inc),
    .trap_req  (trap_req),
    .trap_tt   (trap_tt),
    .trap_ack  (trap_ack)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Starts a fetch at a negedge and acks it after 'delay' extra REQ cycles.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input int delay);
    pc = addr;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    checkOutput("req_rd", mem_rd, 1);
    checkOutput("req_addr", mem_addr, addr);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checkOutput("wait_rd", mem_rd, 1);
      checkOutput("wait_addr", mem_addr, addr);
    end
    mem_ack = 1'b1;
    mem_rdata = data;
    exp_ir.push_back(data);
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic collectIr();
    int n;
    logic [31:0] exp_word;
    n = 0;
    while (!ir_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ir_latency", n, 0);
    checkOutput("ir_valid", ir_valid, 1);
    checkOutput("rd_dropped", mem_rd, 0);
    if (exp_ir.size() == 0) begin
      checkOutput("sb_empty", 0, 1);
    end else begin
      exp_word = exp_ir.pop_front();
      checkOutput("ir_out", ir_out, exp_word);
    end
  endtask

  task automatic consumeIr(input logic [31:0] last_word);
    ir_consume = 1'b1;
    @(negedge clk);
    ir_consume = 1'b0;
    checkOutput("inc_pulse", pcs_inc, 1);
    checkOutput("inc_ir_valid", ir_valid, 0);
    @(negedge clk);
    checkOutput("inc_one_cycle", pcs_inc, 0);
    checkOutput("ir_out_held", ir_out, last_word);
  endtask

  task automatic ackTrap();
    trap_ack = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
    checkOutput("trap_cleared", trap_req, 0);
    checkOutput("tt_cleared", trap_tt, 0);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_ir_out", ir_out, 0);
    checkOutput("rst_ir_valid", ir_valid, 0);
    checkOutput("rst_pcs_inc", pcs_inc, 0);
    checkOutput("rst_trap_req", trap_req, 0);
    checkOutput("rst_trap_tt", trap_tt, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] zero-wait fetch");
    applyStimulus(32'h0000_0100, 32'h0100_0000, 0);
    collectIr();
    consumeIr(32'h0100_0000);

    $display("[TB] misaligned pc");
    pc = 32'h0000_0102;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    checkOutput("mis_no_rd", mem_rd, 0);
    checkOutput("mis_trap", trap_req, 1);
    checkOutput("mis_tt", trap_tt, 8'h07);
    @(negedge clk);
    checkOutput("mis_trap_held", trap_req, 1);
    ackTrap();

    $display("[TB] bus error");
    pc = 32'h0000_0200;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    mem_ack = 1'b1;
    mem_err = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_err = 1'b0;
    checkOutput("err_trap", trap_req, 1);
    checkOutput("err_tt", trap_tt, 8'h21);
    checkOutput("err_ir_valid", ir_valid, 0);
    checkOutput("err_rd", mem_rd, 0);
    @(negedge clk);
    checkOutput("err_no_inc", pcs_inc, 0);
    ackTrap();

    $display("[TB] bus timeout");
    pc = 32'h0000_0300;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    n = 0;
    while (mem_rd && n < 10) begin
      n++;
      @(negedge clk);
    end
    checkOutput("tmo_req_cycles", n, 4);
    checkOutput("tmo_trap", trap_req, 1);
    checkOutput("tmo_tt", trap_tt, 8'h01);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("tmo_late_ack_ir", ir_valid, 0);
    checkOutput("tmo_late_ack_trap", trap_req, 1);
    ackTrap();

    $display("[TB] redirect during REQ");
    pc = 32'h0000_0400;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    redirect = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    checkOutput("redir_rd_kept", mem_rd, 1);
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("redir_rd_done", mem_rd, 0);
    checkOutput("redir_ir_valid", ir_valid, 0);
    checkOutput("redir_no_trap", trap_req, 0);
    @(negedge clk);
    checkOutput("redir_ir_valid2", ir_valid, 0);
    checkOutput("redir_no_inc", pcs_inc, 0);

    $display("[TB] wait-state fetch");
    applyStimulus(32'h0000_0404, 32'h8210_0001, 2);
    collectIr();
    consumeIr(32'h8210_0001);

    $display("[TB] redirect with consume in HOLD");
    applyStimulus(32'h0000_0500, 32'h9DE3_BFA0, 0);
    collectIr();
    ir_consume = 1'b1;
    redirect = 1'b1;
    @(negedge clk);
    ir_consume = 1'b0;
    redirect = 1'b0;
    checkOutput("hold_redir_valid", ir_valid, 0);
    checkOutput("hold_redir_inc", pcs_inc, 0);
    @(negedge clk);
    checkOutput("hold_redir_inc2", pcs_inc, 0);
    checkOutput("hold_redir_idle", mem_rd, 0);

    $display("[TB] reset mid-REQ");
    pc = 32'h0000_0600;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    checkOutput("mid_rd", mem_rd, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_rd", mem_rd, 0);
    checkOutput("arst_addr", mem_addr, 0);
    checkOutput("arst_ir_out", ir_out, 0);
    checkOutput("arst_ir_valid", ir_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_rd", mem_rd, 0);
    checkOutput("post_rst_trap", trap_req, 0);

    $display("[TB] fetch after reset");
    applyStimulus(32'h0000_0700, 32'h0300_0042, 1);
    collectIr();
    consumeIr(32'h0300_0042);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
